// File: rtl/seq_alu.sv
// Sequential ALU. FWD/ADD/AND/OR finish in a single step. Shifts take one
// cycle per bit of shift amount, and MUL is a shift-add loop of WIDTH steps.
// RESULT, ZERO and CARRY are written only when the FSM enters FIN.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for MUL.
  localparam int unsigned CW  = SHW + 1;

  localparam logic [2:0] OpFwd = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpSll = 3'b100;
  localparam logic [2:0] OpSrl = 3'b101;
  localparam logic [2:0] OpRor = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;  // shifted value, or product accumulator for MUL
  logic [WIDTH-1:0] a_q;    // multiplicand, shifted left each MUL step
  logic [WIDTH-1:0] b_q;    // multiplier, shifted right each MUL step
  logic [CW-1:0]    cnt_q;  // steps remaining in RUN

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] fast_val;
  logic             fast_carry;
  logic [WIDTH-1:0] step_val;

  assign shamt = data2[SHW-1:0];
  assign busy  = (state_q != StIdle);

  // Single-step result for the operations that finish at the accept edge.
  always_comb begin
    sum_full   = {1'b0, data1} + {1'b0, data2};
    fast_val   = data2;
    fast_carry = 1'b0;
    case (select)
      OpAdd: begin
        fast_val   = sum_full[WIDTH-1:0];
        fast_carry = sum_full[WIDTH];
      end
      OpAnd:   fast_val = data1 & data2;
      OpOr:    fast_val = data1 | data2;
      default: fast_val = data2;
    endcase
  end

  // One iteration of the latched operation, applied to the accumulator.
  always_comb begin
    step_val = acc_q;
    case (op_q)
      OpSll:   step_val = {acc_q[WIDTH-2:0], 1'b0};
      OpSrl:   step_val = {1'b0, acc_q[WIDTH-1:1]};
      OpRor:   step_val = {acc_q[0], acc_q[WIDTH-1:1]};
      OpMul:   step_val = acc_q + (b_q[0] ? a_q : '0);
      default: step_val = acc_q;
    endcase
  end

  // FSM, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpFwd;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      result  <= '0;
      zero    <= 1'b1;
      carry   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q <= select;
            a_q  <= data1;
            b_q  <= data2;
            case (select)
              OpSll, OpSrl, OpRor: begin
                if (shamt == '0) begin
                  result  <= data1;
                  zero    <= (data1 == '0);
                  carry   <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StFin;
                end else begin
                  acc_q   <= data1;
                  cnt_q   <= {1'b0, shamt};
                  state_q <= StRun;
                end
              end
              OpMul: begin
                acc_q   <= '0;
                cnt_q   <= CW'(WIDTH);
                state_q <= StRun;
              end
              default: begin
                result  <= fast_val;
                zero    <= (fast_val == '0);
                carry   <= fast_carry;
                done    <= 1'b1;
                state_q <= StFin;
              end
            endcase
          end
        end
        StRun: begin
          acc_q <= step_val;
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result  <= step_val;
            zero    <= (step_val == '0);
            carry   <= 1'b0;
            done    <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu (WIDTH=8) with an arithmetic reference model.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] select = 3'b000;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .zero   (zero),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and compare latency and outputs with the model.
  // With noise set, START is toggled with random inputs while the DUT is busy.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] d1, input logic [7:0] d2,
                        input bit noise);
    int s, ai, bi, r, lat, n;
    bit seen;
    logic [7:0] er;
    logic ec;
    ai = int'(d1);
    bi = int'(d2);
    s  = int'(d2[2:0]);
    ec = 1'b0;
    case (sel)
      3'd0: r = bi;
      3'd1: begin r = ai + bi; ec = (r > 255); end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai << s;
      3'd5: r = ai >> s;
      3'd6: r = (ai >> s) | (ai << (8 - s));
      default: r = ai * bi;
    endcase
    er = 8'(r);
    if (sel == 3'd7) lat = 9;
    else if (sel >= 3'd4) lat = (s == 0) ? 1 : s + 1;
    else lat = 1;

    @(negedge clk);
    check("idle_before_start", 32'(busy), 32'd0);
    start  = 1'b1;
    select = sel;
    data1  = d1;
    data2  = d2;
    @(posedge clk);
    #1;
    start  = 1'b0;
    select = 3'($urandom);
    data1  = 8'($urandom);
    data2  = 8'($urandom);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        check($sformatf("latency op%0d", sel), 32'(n), 32'(lat));
        check($sformatf("result op%0d", sel), 32'(result), 32'(er));
        check($sformatf("zero op%0d", sel), 32'(zero), 32'(er == 8'h00));
        check($sformatf("carry op%0d", sel), 32'(carry), 32'(ec));
        check("busy_in_fin", 32'(busy), 32'd1);
      end else if (noise) begin
        start  = 1'($urandom);
        select = 3'($urandom);
        data1  = 8'($urandom);
        data2  = 8'($urandom);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("busy_after_fin", 32'(busy), 32'd0);
    check("result_holds", 32'(result), 32'(er));
  endtask

  initial begin
    // Reset held for one edge.
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_result", 32'(result), 32'h00);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Directed cases.
    run_op(3'd1, 8'hF0, 8'h20, 1'b0);
    run_op(3'd2, 8'hAA, 8'h55, 1'b0);
    run_op(3'd4, 8'h81, 8'h03, 1'b0);
    run_op(3'd6, 8'h81, 8'h01, 1'b0);
    run_op(3'd5, 8'h9C, 8'hF8, 1'b0);
    run_op(3'd7, 8'h0F, 8'h11, 1'b0);
    run_op(3'd7, 8'h10, 8'h10, 1'b0);
    run_op(3'd7, 8'h0F, 8'h11, 1'b1);

    // Reset in the middle of a MUL aborts it.
    @(negedge clk);
    start  = 1'b1;
    select = 3'd7;
    data1  = 8'h0F;
    data2  = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'h00);
    begin
      int stray = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) stray++;
      end
      check("abort_no_done", 32'(stray), 32'd0);
    end
    run_op(3'd0, 8'h33, 8'h5A, 1'b0);

    // Randomised operations.
    repeat (80) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
